// File: rtl/yurut_sonuc_hakemi.sv
// Execute-stage result collector: one FIFO per functional unit, round-robin grant
// of one buffered result per cycle onto a registered writeback port.
module yurut_sonuc_hakemi #(
  parameter int unsigned BIRIM_SAYISI   = 4,
  parameter int unsigned VERI_GEN       = 32,
  parameter int unsigned YAZMAC_ADR_GEN = 5,
  parameter int unsigned FIFO_DERINLIK  = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     durdur_i,
  input  logic                                     bosalt_i,
  input  logic [BIRIM_SAYISI-1:0]                  birim_gecerli_i,
  input  logic [BIRIM_SAYISI*VERI_GEN-1:0]         birim_veri_i,
  input  logic [BIRIM_SAYISI*YAZMAC_ADR_GEN-1:0]   birim_hedef_i,
  input  logic [BIRIM_SAYISI-1:0]                  birim_yaz_i,
  output logic [BIRIM_SAYISI-1:0]                  birim_hazir_o,
  output logic                                     sonuc_gecerli_o,
  output logic [VERI_GEN-1:0]                      sonuc_veri_o,
  output logic [YAZMAC_ADR_GEN-1:0]                sonuc_hedef_o,
  output logic                                     sonuc_yaz_o,
  output logic [$clog2(BIRIM_SAYISI)-1:0]          sonuc_birim_o,
  output logic                                     yurut_stall_o
);

  localparam int unsigned BirimW = $clog2(BIRIM_SAYISI);
  localparam int unsigned PtrW   = $clog2(FIFO_DERINLIK);
  localparam int unsigned CntW   = PtrW + 1;
  // Entry layout: {veri, hedef, yaz}
  localparam int unsigned GirdiW = VERI_GEN + YAZMAC_ADR_GEN + 1;

  // Channel FIFO state
  logic [GirdiW-1:0] mem_q    [BIRIM_SAYISI][FIFO_DERINLIK];
  logic [GirdiW-1:0] mem_d    [BIRIM_SAYISI][FIFO_DERINLIK];
  logic [PtrW-1:0]   wr_ptr_q [BIRIM_SAYISI];
  logic [PtrW-1:0]   wr_ptr_d [BIRIM_SAYISI];
  logic [PtrW-1:0]   rd_ptr_q [BIRIM_SAYISI];
  logic [PtrW-1:0]   rd_ptr_d [BIRIM_SAYISI];
  logic [CntW-1:0]   cnt_q    [BIRIM_SAYISI];
  logic [CntW-1:0]   cnt_d    [BIRIM_SAYISI];

  logic [BIRIM_SAYISI-1:0] dolu, bos, push, pop;

  // Arbiter and writeback registers
  logic [BirimW-1:0]         rr_q, rr_d;
  logic [BirimW-1:0]         aday, secilen;
  logic                      bulundu;
  logic [GirdiW-1:0]         bas;
  logic [VERI_GEN-1:0]       bas_veri;
  logic [YAZMAC_ADR_GEN-1:0] bas_hedef;

  logic                      gecerli_q, gecerli_d;
  logic [VERI_GEN-1:0]       veri_q, veri_d;
  logic [YAZMAC_ADR_GEN-1:0] hedef_q, hedef_d;
  logic                      yaz_q, yaz_d;
  logic [BirimW-1:0]         birim_q, birim_d;

  // Full/empty flags derived from the occupancy counters only
  always_comb begin
    dolu = '0;
    bos  = '0;
    for (int n = 0; n < BIRIM_SAYISI; n++) begin
      dolu[n] = (cnt_q[n] == CntW'(FIFO_DERINLIK));
      bos[n]  = (cnt_q[n] == '0);
    end
  end

  assign birim_hazir_o = ~dolu;
  assign yurut_stall_o = |(birim_gecerli_i & dolu);
  assign push          = birim_gecerli_i & ~dolu & {BIRIM_SAYISI{~bosalt_i}};

  // Round-robin search over non-empty heads starting at the pointer
  always_comb begin
    bulundu = 1'b0;
    secilen = '0;
    aday    = '0;
    for (int unsigned i = 0; i < BIRIM_SAYISI; i++) begin
      aday = BirimW'((32'(rr_q) + i) % BIRIM_SAYISI);
      if (!bulundu && !bos[aday]) begin
        bulundu = 1'b1;
        secilen = aday;
      end
    end
    pop = '0;
    if (bulundu && !durdur_i && !bosalt_i) begin
      pop[secilen] = 1'b1;
    end
    bas       = mem_q[secilen][rd_ptr_q[secilen]];
    bas_veri  = bas[GirdiW-1 -: VERI_GEN];
    bas_hedef = bas[YAZMAC_ADR_GEN:1];
  end

  // FIFO next state: flush clears everything, otherwise independent push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int n = 0; n < BIRIM_SAYISI; n++) begin
      if (bosalt_i) begin
        wr_ptr_d[n] = '0;
        rd_ptr_d[n] = '0;
        cnt_d[n]    = '0;
      end else begin
        if (push[n]) begin
          mem_d[n][wr_ptr_q[n]] = {birim_veri_i[n*VERI_GEN +: VERI_GEN],
                                   birim_hedef_i[n*YAZMAC_ADR_GEN +: YAZMAC_ADR_GEN],
                                   birim_yaz_i[n]};
          wr_ptr_d[n] = wr_ptr_q[n] + PtrW'(1);
        end
        if (pop[n]) begin
          rd_ptr_d[n] = rd_ptr_q[n] + PtrW'(1);
        end
        cnt_d[n] = cnt_q[n] + CntW'(push[n]) - CntW'(pop[n]);
      end
    end
  end

  // Writeback register next state: flush > freeze > grant
  always_comb begin
    gecerli_d = gecerli_q;
    veri_d    = veri_q;
    hedef_d   = hedef_q;
    yaz_d     = yaz_q;
    birim_d   = birim_q;
    rr_d      = rr_q;
    if (bosalt_i) begin
      gecerli_d = 1'b0;
      yaz_d     = 1'b0;
    end else if (!durdur_i) begin
      if (bulundu) begin
        gecerli_d = 1'b1;
        veri_d    = bas_veri;
        hedef_d   = bas_hedef;
        // Writes to x0 are suppressed
        yaz_d     = bas[0] & (bas_hedef != '0);
        birim_d   = secilen;
        rr_d      = (secilen == BirimW'(BIRIM_SAYISI - 1)) ? '0 : secilen + BirimW'(1);
      end else begin
        gecerli_d = 1'b0;
      end
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < BIRIM_SAYISI; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      rr_q      <= '0;
      gecerli_q <= 1'b0;
      veri_q    <= '0;
      hedef_q   <= '0;
      yaz_q     <= 1'b0;
      birim_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      gecerli_q <= gecerli_d;
      veri_q    <= veri_d;
      hedef_q   <= hedef_d;
      yaz_q     <= yaz_d;
      birim_q   <= birim_d;
    end
  end

  // Entry storage needs no reset; occupancy counters guard reads
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign sonuc_gecerli_o = gecerli_q;
  assign sonuc_veri_o    = veri_q;
  assign sonuc_hedef_o   = hedef_q;
  assign sonuc_yaz_o     = yaz_q;
  assign sonuc_birim_o   = birim_q;

endmodule

// File: tb/tb_yurut_sonuc_hakemi.sv
// Directed self-checking bench for the execute-stage result collector.
module tb_yurut_sonuc_hakemi;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         durdur_i;
  logic         bosalt_i;
  logic [3:0]   birim_gecerli_i;
  logic [127:0] birim_veri_i;
  logic [19:0]  birim_hedef_i;
  logic [3:0]   birim_yaz_i;
  logic [3:0]   birim_hazir_o;
  logic         sonuc_gecerli_o;
  logic [31:0]  sonuc_veri_o;
  logic [4:0]   sonuc_hedef_o;
  logic         sonuc_yaz_o;
  logic [1:0]   sonuc_birim_o;
  logic         yurut_stall_o;

  int n_cmp = 0;
  int n_err = 0;

  yurut_sonuc_hakemi #(
    .BIRIM_SAYISI  (4),
    .VERI_GEN      (32),
    .YAZMAC_ADR_GEN(5),
    .FIFO_DERINLIK (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .durdur_i       (durdur_i),
    .bosalt_i       (bosalt_i),
    .birim_gecerli_i(birim_gecerli_i),
    .birim_veri_i   (birim_veri_i),
    .birim_hedef_i  (birim_hedef_i),
    .birim_yaz_i    (birim_yaz_i),
    .birim_hazir_o  (birim_hazir_o),
    .sonuc_gecerli_o(sonuc_gecerli_o),
    .sonuc_veri_o   (sonuc_veri_o),
    .sonuc_hedef_o  (sonuc_hedef_o),
    .sonuc_yaz_o    (sonuc_yaz_o),
    .sonuc_birim_o  (sonuc_birim_o),
    .yurut_stall_o  (yurut_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_unit(input int n, input logic [31:0] v, input logic [4:0] h,
                          input logic y);
    birim_gecerli_i[n]       = 1'b1;
    birim_veri_i[n*32 +: 32] = v;
    birim_hedef_i[n*5 +: 5]  = h;
    birim_yaz_i[n]           = y;
  endtask

  task automatic idle_inputs();
    birim_gecerli_i = '0;
    birim_veri_i    = '0;
    birim_hedef_i   = '0;
    birim_yaz_i     = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic g, input logic [31:0] v,
                           input logic [4:0] h, input logic y, input logic [1:0] b);
    check_eq({tag, ".gecerli"}, 64'(sonuc_gecerli_o), 64'(g));
    check_eq({tag, ".veri"},    64'(sonuc_veri_o),    64'(v));
    check_eq({tag, ".hedef"},   64'(sonuc_hedef_o),   64'(h));
    check_eq({tag, ".yaz"},     64'(sonuc_yaz_o),     64'(y));
    check_eq({tag, ".birim"},   64'(sonuc_birim_o),   64'(b));
  endtask

  initial begin
    durdur_i = 1'b0;
    bosalt_i = 1'b0;
    idle_inputs();
    #1;
    do_reset();

    // Reset state
    check_out("rst", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    check_eq("rst.hazir", 64'(birim_hazir_o), 64'hf);
    check_eq("rst.stall", 64'(yurut_stall_o), 64'h0);

    // 1: single push, visible two edges later
    set_unit(0, 32'h12345678, 5'd5, 1'b1);
    tick();
    idle_inputs();
    check_eq("t1.early", 64'(sonuc_gecerli_o), 64'h0);
    tick();
    check_out("t1", 1'b1, 32'h12345678, 5'd5, 1'b1, 2'd0);
    tick();
    check_eq("t1.drop", 64'(sonuc_gecerli_o), 64'h0);

    // 2: four simultaneous pushes from a fresh pointer drain 0,1,2,3
    do_reset();
    for (int n = 0; n < 4; n++) set_unit(n, 32'hA0 + 32'(n), 5'(n + 1), 1'b1);
    tick();
    idle_inputs();
    for (int n = 0; n < 4; n++) begin
      tick();
      check_out($sformatf("t2.g%0d", n), 1'b1, 32'hA0 + 32'(n), 5'(n + 1), 1'b1, 2'(n));
    end
    tick();
    check_eq("t2.idle", 64'(sonuc_gecerli_o), 64'h0);
    // Pointer back at 0: unit 0 wins over unit 3
    set_unit(0, 32'hB0, 5'd9, 1'b1);
    set_unit(3, 32'hB3, 5'd10, 1'b1);
    tick();
    idle_inputs();
    tick();
    check_out("t2.wrap0", 1'b1, 32'hB0, 5'd9, 1'b1, 2'd0);
    tick();
    check_out("t2.wrap3", 1'b1, 32'hB3, 5'd10, 1'b1, 2'd3);
    tick();

    // 3: three pushes into unit 2 under freeze, then drain in order
    durdur_i = 1'b1;
    set_unit(2, 32'hD1, 5'd7, 1'b1);
    #1;
    check_eq("t3.hazir0", 64'(birim_hazir_o), 64'hf);
    tick();
    set_unit(2, 32'hD2, 5'd7, 1'b1);
    tick();
    set_unit(2, 32'hD3, 5'd7, 1'b1);
    #1;
    check_eq("t3.hazir", 64'(birim_hazir_o), 64'hb);
    check_eq("t3.stall", 64'(yurut_stall_o), 64'h1);
    tick();
    check_eq("t3.frozen", 64'(sonuc_gecerli_o), 64'h0);
    check_eq("t3.stall2", 64'(yurut_stall_o), 64'h1);
    durdur_i = 1'b0;
    tick();
    check_out("t3.d1", 1'b1, 32'hD1, 5'd7, 1'b1, 2'd2);
    check_eq("t3.hazir1", 64'(birim_hazir_o), 64'hf);
    tick();
    idle_inputs();
    check_out("t3.d2", 1'b1, 32'hD2, 5'd7, 1'b1, 2'd2);
    tick();
    check_out("t3.d3", 1'b1, 32'hD3, 5'd7, 1'b1, 2'd2);
    tick();
    check_eq("t3.idle", 64'(sonuc_gecerli_o), 64'h0);

    // 4: destination x0 suppresses the write (pointer now 3, unit 1 is only candidate)
    set_unit(1, 32'hDEAD, 5'd0, 1'b1);
    tick();
    idle_inputs();
    tick();
    check_out("t4", 1'b1, 32'hDEAD, 5'd0, 1'b0, 2'd1);
    tick();

    // 5: flush with entries in channels 0 and 3 (pointer now 2)
    set_unit(0, 32'hE0, 5'd1, 1'b1);
    set_unit(3, 32'hE3, 5'd3, 1'b1);
    tick();
    set_unit(0, 32'hF0, 5'd2, 1'b1);
    set_unit(3, 32'hF3, 5'd4, 1'b1);
    tick();
    check_out("t5.pre", 1'b1, 32'hE3, 5'd3, 1'b1, 2'd3);
    bosalt_i = 1'b1;
    tick();
    bosalt_i = 1'b0;
    idle_inputs();
    check_eq("t5.gecerli", 64'(sonuc_gecerli_o), 64'h0);
    check_eq("t5.yaz", 64'(sonuc_yaz_o), 64'h0);
    check_eq("t5.hazir", 64'(birim_hazir_o), 64'hf);
    check_eq("t5.veri_hold", 64'(sonuc_veri_o), 64'hE3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t5.stale%0d", k), 64'(sonuc_gecerli_o), 64'h0);
    end

    // 6: reset while every channel is full
    durdur_i = 1'b1;
    for (int n = 0; n < 4; n++) set_unit(n, 32'hC0 + 32'(n), 5'd6, 1'b1);
    tick();
    tick();
    idle_inputs();
    #1;
    check_eq("t6.full", 64'(birim_hazir_o), 64'h0);
    durdur_i = 1'b0;
    do_reset();
    check_out("t6.rst", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    check_eq("t6.hazir", 64'(birim_hazir_o), 64'hf);
    set_unit(2, 32'h55AA, 5'd12, 1'b1);
    tick();
    idle_inputs();
    check_eq("t6.early", 64'(sonuc_gecerli_o), 64'h0);
    tick();
    check_out("t6.new", 1'b1, 32'h55AA, 5'd12, 1'b1, 2'd2);
    tick();
    check_eq("t6.idle", 64'(sonuc_gecerli_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
